// File: rtl/rom_backdoor_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_backdoor_bridge_pkg
// Description : Shared types and constants for the AXI4-Lite to ROM backdoor
//               bridge: FSM state encoding and AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_backdoor_bridge_pkg;

  // Explicit 3-bit encoding so the state register width is fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_BRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RCAP  = 3'd4,
    ST_RRESP = 3'd5
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rom_backdoor_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : rom_backdoor_axi_bridge
// Description : AXI4-Lite slave that turns single-beat reads and writes into
//               one-cycle accesses on the ROM backdoor BRAM port. One
//               transaction is outstanding at a time; out-of-range addresses
//               are answered with SLVERR without touching the BRAM.
// Ports       : rom_backdoor_clk/rst  - clock, async active-high reset
//               S_AXI_ROM_*           - AXI4-Lite slave (AW, W, B, AR, R)
//               rom_backdoor_en/we/addr/din - registered BRAM port controls
//               rom_backdoor_dout     - BRAM read data, 1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module rom_backdoor_axi_bridge
  import rom_backdoor_bridge_pkg::*;
#(
  parameter int              ROM_ADDR_W = 17,
  parameter longint unsigned ROM_BYTES  = 64'd1 << ROM_ADDR_W
) (
  input  logic                  rom_backdoor_clk,
  input  logic                  rom_backdoor_rst,
  input  logic                  S_AXI_ROM_AWVALID,
  output logic                  S_AXI_ROM_AWREADY,
  input  logic [31:0]           S_AXI_ROM_AWADDR,
  input  logic                  S_AXI_ROM_WVALID,
  output logic                  S_AXI_ROM_WREADY,
  input  logic [31:0]           S_AXI_ROM_WDATA,
  input  logic [3:0]            S_AXI_ROM_WSTRB,
  output logic                  S_AXI_ROM_BVALID,
  input  logic                  S_AXI_ROM_BREADY,
  output logic [1:0]            S_AXI_ROM_BRESP,
  input  logic                  S_AXI_ROM_ARVALID,
  output logic                  S_AXI_ROM_ARREADY,
  input  logic [31:0]           S_AXI_ROM_ARADDR,
  output logic                  S_AXI_ROM_RVALID,
  input  logic                  S_AXI_ROM_RREADY,
  output logic [31:0]           S_AXI_ROM_RDATA,
  output logic [1:0]            S_AXI_ROM_RRESP,
  output logic                  rom_backdoor_en,
  output logic [3:0]            rom_backdoor_we,
  output logic [ROM_ADDR_W-1:0] rom_backdoor_addr,
  output logic [31:0]           rom_backdoor_din,
  input  logic [31:0]           rom_backdoor_dout
);

  bridge_state_e         state_q, state_d;
  logic                  en_q, en_d;
  logic [3:0]            we_q, we_d;
  logic [ROM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;

  logic wr_req;
  logic aw_in_range;
  logic ar_in_range;
  logic idle;

  assign wr_req      = S_AXI_ROM_AWVALID && S_AXI_ROM_WVALID;
  // Full-width compare: no wrap, so ROM_BYTES itself is out of range.
  assign aw_in_range = ({32'd0, S_AXI_ROM_AWADDR} < ROM_BYTES);
  assign ar_in_range = ({32'd0, S_AXI_ROM_ARADDR} < ROM_BYTES);
  assign idle        = (state_q == ST_IDLE);

  // Readies are gated by reset so every output is 0 while reset is held.
  assign S_AXI_ROM_AWREADY = !rom_backdoor_rst && idle && wr_req;
  assign S_AXI_ROM_WREADY  = !rom_backdoor_rst && idle && wr_req;
  assign S_AXI_ROM_ARREADY = !rom_backdoor_rst && idle && S_AXI_ROM_ARVALID && !wr_req;

  always_comb begin
    state_d  = state_q;
    en_d     = 1'b0;
    we_d     = 4'h0;
    addr_d   = addr_q;
    din_d    = din_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          if (aw_in_range) begin
            state_d = ST_WR;
            en_d    = 1'b1;
            we_d    = S_AXI_ROM_WSTRB;
            addr_d  = {S_AXI_ROM_AWADDR[ROM_ADDR_W-1:2], 2'b00};
            din_d   = S_AXI_ROM_WDATA;
          end else begin
            state_d  = ST_BRESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
          end
        end else if (S_AXI_ROM_ARVALID) begin
          if (ar_in_range) begin
            state_d = ST_RD;
            en_d    = 1'b1;
            addr_d  = {S_AXI_ROM_ARADDR[ROM_ADDR_W-1:2], 2'b00};
          end else begin
            state_d  = ST_RRESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = 32'h0;
          end
        end
      end
      ST_WR: begin
        state_d  = ST_BRESP;
        bvalid_d = 1'b1;
        bresp_d  = RESP_OKAY;
      end
      ST_BRESP: begin
        if (S_AXI_ROM_BREADY) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
        end
      end
      ST_RD: begin
        // BRAM samples the address this cycle; data appears during RCAP.
        state_d = ST_RCAP;
      end
      ST_RCAP: begin
        state_d  = ST_RRESP;
        rvalid_d = 1'b1;
        rresp_d  = RESP_OKAY;
        rdata_d  = rom_backdoor_dout;
      end
      ST_RRESP: begin
        if (S_AXI_ROM_RREADY) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rom_backdoor_clk or posedge rom_backdoor_rst) begin
    if (rom_backdoor_rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      we_q     <= 4'h0;
      addr_q   <= '0;
      din_q    <= 32'h0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign S_AXI_ROM_BVALID  = bvalid_q;
  assign S_AXI_ROM_BRESP   = bresp_q;
  assign S_AXI_ROM_RVALID  = rvalid_q;
  assign S_AXI_ROM_RRESP   = rresp_q;
  assign S_AXI_ROM_RDATA   = rdata_q;
  assign rom_backdoor_en   = en_q;
  assign rom_backdoor_we   = we_q;
  assign rom_backdoor_addr = addr_q;
  assign rom_backdoor_din  = din_q;

endmodule
`default_nettype wire

// File: doc/rom_backdoor_axi_bridge.md
ROM_BACKDOOR_AXI_BRIDGE -- requirements
Module: rom_backdoor_axi_bridge

Interface
REQ-001 SHALL have parameter ROM_ADDR_W, default 17, meaning ROM backdoor byte-address width.
REQ-002 SHALL have parameter ROM_BYTES, default 2**ROM_ADDR_W, meaning the byte size of the ROM window; addresses at or above it are out of range.
REQ-003 SHALL have the following ports:
- rom_backdoor_clk  in  1  sole clock.
- rom_backdoor_rst  in  1  asynchronous, active-high reset.
- S_AXI_ROM_AWVALID/AWREADY  in/out  1/1  AXI4-Lite write-address handshake.
- S_AXI_ROM_AWADDR  in  32  write byte address.
- S_AXI_ROM_WVALID/WREADY  in/out  1/1  write-data handshake.
- S_AXI_ROM_WDATA  in  32  write data.
- S_AXI_ROM_WSTRB  in  4  byte strobes.
- S_AXI_ROM_BVALID/BREADY  out/in  1/1  write-response handshake.
- S_AXI_ROM_BRESP  out  2  write response.
- S_AXI_ROM_ARVALID/ARREADY  in/out  1/1  read-address handshake.
- S_AXI_ROM_ARADDR  in  32  read byte address.
- S_AXI_ROM_RVALID/RREADY  out/in  1/1  read-data handshake.
- S_AXI_ROM_RDATA  out  32  read data.
- S_AXI_ROM_RRESP  out  2  read response.
- rom_backdoor_en  out  1  BRAM port enable.
- rom_backdoor_we  out  4  BRAM byte write enables.
- rom_backdoor_addr  out  ROM_ADDR_W  BRAM byte address, with bits [1:0] forced to 0.
- rom_backdoor_din  out  32  BRAM write data.
- rom_backdoor_dout  in  32  BRAM read data, valid 1 cycle after an enabled read.

Function
REQ-004 SHALL implement the FSM states IDLE, WR, BRESP, RD, RCAP, RRESP.
REQ-005 In IDLE, AWREADY and WREADY SHALL both be high only when AWVALID and WVALID are both high; the AW and W channels are accepted together in the same cycle.
REQ-006 In IDLE, ARREADY SHALL be high only when ARVALID is high and (AWVALID and WVALID) is not both high; writes win a simultaneous request.
REQ-007 An accepted in-range write (AWADDR < ROM_BYTES) SHALL go to WR, driving for exactly one cycle: en=1, we=WSTRB, addr=AWADDR[ROM_ADDR_W-1:2]<<2, din=WDATA.
REQ-008 After WR, the FSM SHALL go to BRESP with BVALID=1 and BRESP=OKAY (2'b00); BVALID therefore rises 2 cycles after the AW/W handshake.
REQ-009 An accepted write with WSTRB=0 SHALL still issue the WR cycle, with we=0.
REQ-010 An accepted in-range read SHALL go to RD (en=1, we=0, addr as for writes, one cycle), then RCAP (register rom_backdoor_dout into RDATA), then RRESP with RVALID=1 and RRESP=OKAY; RVALID rises 3 cycles after the AR handshake.
REQ-011 An out-of-range request SHALL never assert en, and SHALL go directly to BRESP or RRESP with response SLVERR (2'b10) and RDATA=0; the response rises 1 cycle after the handshake.
REQ-012 BVALID and RVALID, together with their RESP and RDATA values, SHALL be held stable until BREADY or RREADY is high; the FSM then returns to IDLE in the next cycle.
REQ-013 Only one transaction SHALL be outstanding at a time; no ready is asserted outside IDLE.
REQ-014 The address SHALL NOT wrap: an address equal to ROM_BYTES is out of range.
REQ-015 en, we, addr and din SHALL be registered outputs; en and we are 0 in every state except WR and RD.

Reset
REQ-016 While rom_backdoor_rst is high, the FSM SHALL be in IDLE and every output SHALL be 0 (ready, valid, RESP, RDATA, en, we, addr, din).
REQ-017 A reset asserted mid-transaction SHALL abandon that transaction: no response is issued and no further BRAM access occurs; a BRAM write already issued in WR is not undone.
REQ-018 After reset deasserts, the first handshake SHALL be possible on the first clock edge.

Structure
REQ-019 Package rom_backdoor_bridge_pkg SHALL hold the FSM state enum and the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-020 The block SHALL be a single module with no sub-modules; it sits upstream of the Caliptra wrapper's ROM backdoor port and is clocked and reset by that port's rom_backdoor_clk and rom_backdoor_rst.

Verification
REQ-021 Write AWADDR=0x104, WDATA=0xDEADBEEF, WSTRB=0xF -> one en cycle with we=0xF and addr=0x104; BVALID 2 cycles later with BRESP=0.
REQ-022 Read ARADDR=0x104 with the BRAM model returning 0xDEADBEEF -> one en cycle with we=0; RVALID 3 cycles after the handshake with RDATA=0xDEADBEEF and RRESP=0.
REQ-023 AWVALID, WVALID and ARVALID asserted in the same cycle -> the write completes first, then ARREADY is asserted in the next IDLE cycle.
REQ-024 Read ARADDR=0x20000 (ROM_ADDR_W=17) -> en never asserted; RVALID 1 cycle later with RRESP=2'b10 and RDATA=0.
REQ-025 RREADY held low for 5 cycles -> RVALID and RDATA stable throughout; FSM returns to IDLE the cycle after RREADY rises.
REQ-026 Reset asserted during RCAP -> all outputs 0 immediately; no RVALID after reset deasserts.
